// File: rtl/uart_bus_pkg.sv
// Shared command/response encodings and FSM state type for the UART Wishbone
// execution stage.
package uart_bus_pkg;

  localparam logic [1:0] CMD_READ    = 2'b00;
  localparam logic [1:0] CMD_WRITE   = 2'b01;
  localparam logic [1:0] CMD_ADDR    = 2'b10;
  localparam logic [1:0] CMD_SPECIAL = 2'b11;

  localparam logic [1:0] RSP_RDATA   = 2'b00;
  localparam logic [1:0] RSP_WACK    = 2'b01;
  localparam logic [1:0] RSP_ADDR    = 2'b10;
  localparam logic [1:0] RSP_SPECIAL = 2'b11;

  localparam logic [31:0] ERR_BUS     = 32'hFFFF_FFFE;
  localparam logic [31:0] ERR_TIMEOUT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_RESP
  } state_e;

endpackage

// File: rtl/uart_wb_watchdog.sv
// Bus watchdog: counts cycles while a bus transaction is outstanding and flags
// expiry on the LIMIT-th cycle. Cleared whenever a new command is accepted.
module uart_wb_watchdog #(
  parameter int unsigned LIMIT = 1024
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_run,
  output logic o_expired
);

  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q;

  // Cycle counter, held when the bus is idle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else if (i_clear) begin
      cnt_q <= '0;
    end else if (i_run) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign o_expired = i_run && (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/uart_wb_exec.sv
// Executes decoded UART commands as single Wishbone pipelined transactions and
// returns one response word per command. Optional bus watchdog is enabled by
// defining UART_WB_TIMEOUT_EN.
module uart_wb_exec
  import uart_bus_pkg::*;
#(
  parameter int unsigned AW             = 30,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_cmd_stb,
  input  logic [33:0]   i_cmd_word,
  output logic          o_cmd_busy,
  output logic          o_wb_cyc,
  output logic          o_wb_stb,
  output logic          o_wb_we,
  output logic [AW-1:0] o_wb_addr,
  output logic [31:0]   o_wb_data,
  input  logic          i_wb_stall,
  input  logic          i_wb_ack,
  input  logic          i_wb_err,
  input  logic [31:0]   i_wb_data,
  output logic          o_rsp_stb,
  output logic [33:0]   o_rsp_word
);

  state_e        state_q, state_d;
  logic          cyc_q, cyc_d;
  logic          stb_q, stb_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [33:0]   rsp_q, rsp_d;
  logic          wd_expired;

`ifdef UART_WB_TIMEOUT_EN
  logic wd_clear;
  logic wd_run;

  assign wd_clear = (state_q == ST_IDLE) && i_cmd_stb;
  assign wd_run   = (state_q == ST_REQ) || (state_q == ST_WAIT);

  uart_wb_watchdog #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_watchdog (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clear  (wd_clear),
    .i_run    (wd_run),
    .o_expired(wd_expired)
  );
`else
  assign wd_expired = 1'b0;
`endif

  // State and datapath registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rsp_q   <= rsp_d;
    end
  end

  // Next-state: command acceptance, bus handshake, completion and response
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    stb_d   = stb_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rsp_d   = rsp_q;

    unique case (state_q)
      ST_IDLE: begin
        if (i_cmd_stb) begin
          unique case (i_cmd_word[33:32])
            CMD_READ, CMD_WRITE: begin
              we_d    = i_cmd_word[32];
              wdata_d = i_cmd_word[31:0];
              cyc_d   = 1'b1;
              stb_d   = 1'b1;
              state_d = ST_REQ;
            end
            CMD_ADDR: begin
              addr_d  = i_cmd_word[AW-1:0];
              rsp_d   = {RSP_ADDR, 32'(i_cmd_word[AW-1:0])};
              state_d = ST_RESP;
            end
            default: begin
              rsp_d   = {RSP_SPECIAL, 1'b0, i_cmd_word[30:0]};
              state_d = ST_RESP;
            end
          endcase
        end
      end
      ST_REQ: begin
        if (!i_wb_stall) begin
          stb_d   = 1'b0;
          state_d = ST_WAIT;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: ;
    endcase

    // Completion is shared by WAIT and the stall-release cycle of REQ, so it
    // overrides the REQ->WAIT step above; err outranks ack, both outrank expiry.
    if ((state_q == ST_WAIT) || ((state_q == ST_REQ) && !i_wb_stall)) begin
      if (i_wb_err) begin
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
        rsp_d   = {RSP_SPECIAL, ERR_BUS};
        state_d = ST_RESP;
      end else if (i_wb_ack) begin
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
        rsp_d   = we_q ? {RSP_WACK, wdata_q} : {RSP_RDATA, i_wb_data};
        addr_d  = addr_q + AW'(1);
        state_d = ST_RESP;
      end else if (wd_expired) begin
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
        rsp_d   = {RSP_SPECIAL, ERR_TIMEOUT};
        state_d = ST_RESP;
      end
    end else if ((state_q == ST_REQ) && wd_expired) begin
      cyc_d   = 1'b0;
      stb_d   = 1'b0;
      rsp_d   = {RSP_SPECIAL, ERR_TIMEOUT};
      state_d = ST_RESP;
    end
  end

  assign o_cmd_busy = (state_q != ST_IDLE);
  assign o_rsp_stb  = (state_q == ST_RESP);
  assign o_rsp_word = rsp_q;
  assign o_wb_cyc   = cyc_q;
  assign o_wb_stb   = stb_q;
  assign o_wb_we    = we_q;
  assign o_wb_addr  = addr_q;
  assign o_wb_data  = wdata_q;

endmodule

// File: tb/tb_uart_wb_exec.sv
// Self-checking bench for uart_wb_exec. Timeout scenario runs when
// UART_WB_TIMEOUT_EN is defined for the build.
module tb_uart_wb_exec;

  localparam int unsigned AW = 30;
  localparam longint unsigned AMASK = (64'd1 << AW) - 1;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_cmd_stb = 1'b0;
  logic [33:0]   i_cmd_word = '0;
  logic          o_cmd_busy;
  logic          o_wb_cyc, o_wb_stb, o_wb_we;
  logic [AW-1:0] o_wb_addr;
  logic [31:0]   o_wb_data;
  logic          i_wb_stall = 1'b0;
  logic          i_wb_ack = 1'b0;
  logic          i_wb_err = 1'b0;
  logic [31:0]   i_wb_data = '0;
  logic          o_rsp_stb;
  logic [33:0]   o_rsp_word;

  uart_wb_exec #(.AW(AW), .TIMEOUT_CYCLES(16)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_cmd_stb(i_cmd_stb), .i_cmd_word(i_cmd_word),
    .o_cmd_busy(o_cmd_busy), .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
    .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .i_wb_stall(i_wb_stall),
    .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err), .i_wb_data(i_wb_data),
    .o_rsp_stb(o_rsp_stb), .o_rsp_word(o_rsp_word)
  );

  always #5 i_clk = ~i_clk;

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    logic [31:0]   data;
  } bus_t;

  bus_t            bus_q[$];
  logic [33:0]     rsp_q[$];
  longint unsigned m_addr = 0;

  // slave configuration: 0 ack, 1 err, 2 ack+err, 3 silent
  int          slv_mode = 0;
  int          stall_left = 0;
  logic [31:0] slv_rdata = '0;

  function automatic void model_cmd(input logic [1:0] cmd, input logic [31:0] pl);
    bus_t b;
    if (cmd == 2'b00 || cmd == 2'b01) begin
      b.addr = AW'(m_addr);
      b.we   = cmd[0];
      b.data = pl;
      bus_q.push_back(b);
      if (slv_mode == 1 || slv_mode == 2) begin
        rsp_q.push_back({2'b11, 32'hFFFF_FFFE});
      end else if (slv_mode == 0) begin
        rsp_q.push_back(cmd[0] ? {2'b01, pl} : {2'b00, slv_rdata});
        m_addr = (m_addr + 1) & AMASK;
      end else begin
`ifdef UART_WB_TIMEOUT_EN
        rsp_q.push_back({2'b11, 32'hFFFF_FFFF});
`endif
      end
    end else if (cmd == 2'b10) begin
      m_addr = longint'(pl) & AMASK;
      rsp_q.push_back({2'b10, 32'(m_addr)});
    end else begin
      rsp_q.push_back({2'b11, pl & 32'h7FFF_FFFF});
    end
  endfunction

  // ---------------- slave ----------------
  bit pend = 0;
  initial begin
    forever begin
      @(posedge i_clk);
      #1;
      i_wb_ack = 1'b0;
      i_wb_err = 1'b0;
      if (!i_rst_n) begin
        pend = 0;
        i_wb_stall = 1'b0;
      end else begin
        if (pend) begin
          pend = 0;
          i_wb_data = slv_rdata;
          case (slv_mode)
            0: i_wb_ack = 1'b1;
            1: i_wb_err = 1'b1;
            2: begin i_wb_ack = 1'b1; i_wb_err = 1'b1; end
            default: ;
          endcase
        end
        if (o_wb_cyc && o_wb_stb) begin
          if (stall_left > 0) begin
            i_wb_stall = 1'b1;
            stall_left--;
          end else begin
            i_wb_stall = 1'b0;
            pend = 1;
          end
        end else begin
          i_wb_stall = 1'b0;
        end
      end
    end
  end

  // ---------------- compare process ----------------
  int stb_cycles = 0;
  always @(negedge i_clk) begin
    if (i_rst_n) begin
      if (o_wb_stb) stb_cycles++;
      if (o_wb_stb && !o_wb_cyc) chk("stb_without_cyc", 64'(o_wb_cyc), 64'd1);
      if (o_wb_cyc && o_wb_stb && !i_wb_stall) begin
        if (bus_q.size() == 0) begin
          chk("unexpected_bus_req", 64'(bus_q.size()), 64'd1);
        end else begin
          bus_t e;
          e = bus_q.pop_front();
          chk("bus_addr", 64'(o_wb_addr), 64'(e.addr));
          chk("bus_we", 64'(o_wb_we), 64'(e.we));
          chk("bus_data", 64'(o_wb_data), 64'(e.data));
        end
      end
      if (o_rsp_stb) begin
        if (rsp_q.size() == 0) begin
          chk("unexpected_rsp", 64'(rsp_q.size()), 64'd1);
        end else begin
          logic [33:0] r;
          r = rsp_q.pop_front();
          chk("rsp_word", 64'(o_rsp_word), 64'(r));
        end
      end
    end
  end

  // ---------------- directed driver ----------------
  logic [33:0] last_rsp;

  task automatic run_cmd(input logic [1:0] cmd, input logic [31:0] pl, input int exp_lat,
                         input bit dup, input string nm);
    int lat;
    bit got;
    model_cmd(cmd, pl);
    stb_cycles = 0;
    @(posedge i_clk); #1;
    i_cmd_stb  = 1'b1;
    i_cmd_word = {cmd, pl};
    @(posedge i_clk); #1;
    if (dup) i_cmd_word = {2'b01, 32'hFFFF_0000};
    else     i_cmd_stb = 1'b0;
    lat = 1;
    got = 0;
    while (!got && lat < 200) begin
      @(negedge i_clk);
      if (dup && lat == 1) chk({nm, "_busy_at_dup"}, 64'(o_cmd_busy), 64'd1);
      if (lat == 2) i_cmd_stb = 1'b0;
      if (o_rsp_stb) begin
        got = 1;
        last_rsp = o_rsp_word;
        chk({nm, "_busy_in_rsp"}, 64'(o_cmd_busy), 64'd1);
      end else begin
        lat++;
      end
    end
    i_cmd_stb = 1'b0;
    if (!got) chk({nm, "_rsp_timeout"}, 64'd0, 64'd1);
    else      chk({nm, "_latency"}, 64'(lat), 64'(exp_lat));
    @(negedge i_clk);
    chk({nm, "_busy_after"}, 64'(o_cmd_busy), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit: got timeout expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    // reset values
    repeat (2) @(negedge i_clk);
    chk("rst_cyc", 64'(o_wb_cyc), 64'd0);
    chk("rst_stb", 64'(o_wb_stb), 64'd0);
    chk("rst_we", 64'(o_wb_we), 64'd0);
    chk("rst_rsp_stb", 64'(o_rsp_stb), 64'd0);
    chk("rst_busy", 64'(o_cmd_busy), 64'd0);
    chk("rst_addr", 64'(o_wb_addr), 64'd0);
    chk("rst_data", 64'(o_wb_data), 64'd0);
    chk("rst_rsp_word", 64'(o_rsp_word), 64'd0);
    i_rst_n = 1'b1;
    repeat (2) @(negedge i_clk);

    // set address then zero-wait read
    run_cmd(2'b10, 32'h0000_0100, 1, 0, "setaddr");
    chk("setaddr_lit", 64'(last_rsp), 64'h2_0000_0100);
    slv_mode = 0; slv_rdata = 32'hCAFE_F00D;
    run_cmd(2'b00, 32'h0, 3, 0, "read1");
    chk("read1_lit", 64'(last_rsp), 64'h0_CAFE_F00D);
    chk("addr_after_read1", 64'(o_wb_addr), 64'h101);

    // write with three stall cycles
    run_cmd(2'b10, 32'h0000_0020, 1, 0, "setaddr20");
    stall_left = 3;
    run_cmd(2'b01, 32'h1234_5678, 6, 0, "wr_stall");
    chk("wr_stall_lit", 64'(last_rsp), 64'h1_1234_5678);
    chk("wr_stall_stb_cycles", 64'(stb_cycles), 64'd4);
    slv_rdata = 32'hDEAD_BEEF;
    run_cmd(2'b00, 32'h0, 3, 0, "read21");

    // bus error with simultaneous ack: error wins, address held
    slv_mode = 2;
    run_cmd(2'b00, 32'h0, 3, 0, "buserr");
    chk("buserr_lit", 64'(last_rsp), 64'h3_FFFF_FFFE);
    chk("addr_after_err", 64'(o_wb_addr), 64'h22);
    slv_mode = 1;
    run_cmd(2'b01, 32'h7777_0001, 3, 0, "buserr_wr");
    slv_mode = 0; slv_rdata = 32'h0BAD_F00D;
    run_cmd(2'b00, 32'h0, 3, 0, "read22");

    // command while busy is dropped
    slv_rdata = 32'h55AA_33CC;
    run_cmd(2'b00, 32'h0, 3, 1, "dup");
    repeat (4) @(negedge i_clk);
    run_cmd(2'b11, 32'h8000_0053, 1, 0, "ping");
    chk("ping_lit", 64'(last_rsp), 64'h3_0000_0053);

    // address wrap
    run_cmd(2'b10, 32'h3FFF_FFFF, 1, 0, "setaddr_top");
    run_cmd(2'b01, 32'hA5A5_A5A5, 3, 0, "wr_top");
    chk("wrap_addr", 64'(o_wb_addr), 64'h0);
    slv_rdata = 32'h0000_1111;
    run_cmd(2'b00, 32'h0, 3, 0, "read_wrapped");

    // reset asserted while waiting for a silent slave
    slv_mode = 3;
    model_cmd(2'b00, 32'h0);
    @(posedge i_clk); #1;
    i_cmd_stb = 1'b1; i_cmd_word = {2'b00, 32'h0};
    @(posedge i_clk); #1;
    i_cmd_stb = 1'b0;
    repeat (3) @(negedge i_clk);
    chk("midwait_cyc", 64'(o_wb_cyc), 64'd1);
    chk("midwait_stb", 64'(o_wb_stb), 64'd0);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("rst_drop_cyc", 64'(o_wb_cyc), 64'd0);
    chk("rst_drop_busy", 64'(o_cmd_busy), 64'd0);
    rsp_q.delete();
    bus_q.delete();
    m_addr = 0;
    repeat (2) @(negedge i_clk);
    chk("rst_no_rsp", 64'(o_rsp_stb), 64'd0);
    i_rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge i_clk);
      chk("post_rst_no_rsp", 64'(o_rsp_stb), 64'd0);
    end
    chk("post_rst_addr", 64'(o_wb_addr), 64'h0);

`ifdef UART_WB_TIMEOUT_EN
    slv_mode = 3;
    run_cmd(2'b10, 32'h0000_0040, 1, 0, "setaddr40");
    run_cmd(2'b00, 32'h0, 17, 0, "timeout");
    chk("timeout_lit", 64'(last_rsp), 64'h3_FFFF_FFFF);
    chk("timeout_addr", 64'(o_wb_addr), 64'h40);
    slv_mode = 0; slv_rdata = 32'h0000_2222;
    run_cmd(2'b00, 32'h0, 3, 0, "read_after_to");
`endif

    repeat (4) @(negedge i_clk);
    chk("rsp_queue_empty", 64'(rsp_q.size()), 64'd0);
    chk("bus_queue_empty", 64'(bus_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/uart_wb_exec.md
Name: uart_wb_exec

Overview:
- Downstream stage of the UART command decoder.
- Consumes 34-bit decoded command words {cmd[1:0], data[31:0]} and executes them as single Wishbone (classic, pipelined-stall) transactions.
- Returns one 34-bit response word per command to the UART transmit path.
- Holds the current bus address; address auto-increments after every read/write.

Parameters:
- AW, 30, Wishbone word-address width.
- TIMEOUT_CYCLES, 1024, bus watchdog limit in clocks (used only with the optional feature).

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_cmd_stb  in  1  command word valid, single-cycle pulse
- i_cmd_word  in  34  [33:32] cmd: 00 read, 01 write, 10 set address, 11 special; [31:0] payload
- o_cmd_busy  out  1  high while a command is in progress; commands arriving while high are dropped
- o_wb_cyc  out  1  bus cycle
- o_wb_stb  out  1  bus strobe
- o_wb_we  out  1  write enable
- o_wb_addr  out  AW  word address
- o_wb_data  out  32  write data
- i_wb_stall  in  1  slave stall
- i_wb_ack  in  1  slave acknowledge
- i_wb_err  in  1  slave error
- i_wb_data  in  32  read data
- o_rsp_stb  out  1  response valid, single-cycle pulse, not back-pressurable
- o_rsp_word  out  34  [33:32] tag: 00 read data, 01 write ack, 10 address echo, 11 special/error; [31:0] payload

Behaviour:
- Reset (async, immediate):
  - state = IDLE.
  - Outputs cyc/stb/we/rsp_stb/cmd_busy = 0.
  - addr = 0, o_wb_data = 0, o_rsp_word = 0.
  - Asserting reset mid-transaction drops cyc/stb at once; no response is issued.
- States: IDLE, REQ, WAIT, RESP.
- IDLE:
  - Accepts a command when i_cmd_stb && !o_cmd_busy; a command is accepted only in IDLE.
  - read/write:
    - Capture o_wb_we = cmd[0] and o_wb_data = payload.
    - Next cycle cyc = stb = 1, state = REQ, busy = 1.
  - set address:
    - addr <= payload[AW-1:0].
    - Next cycle respond with tag 10, payload = addr zero-extended to 32 bits.
    - No bus cycle.
  - special:
    - Next cycle respond with tag 11, payload {1'b0, payload[30:0]} (ping).
    - No bus cycle.
- REQ: stb stays high until a cycle with !i_wb_stall; then stb <= 0, state = WAIT, cyc stays high.
- WAIT:
  - i_wb_ack: cyc <= 0.
    - Read: capture i_wb_data with tag 00.
    - Write: tag 01 with payload = written data.
    - addr <= addr + 1, wrapping modulo 2^AW.
    - State = RESP.
  - i_wb_err: cyc <= 0, tag 11, payload 32'hFFFF_FFFE, addr unchanged, state = RESP.
  - ack and err in the same cycle: err wins.
  - ack/err arriving already in REQ in the stall-release cycle: handled the same as in WAIT (REQ → RESP directly).
- RESP: o_rsp_stb = 1 for exactly one cycle with o_rsp_word valid; state = IDLE.
- o_cmd_busy:
  - Is 1 from the cycle after acceptance until the cycle after o_rsp_stb.
  - Also 1 during the one-cycle response of set-address/special commands.
- Latencies:
  - Read/write with zero-wait slave (no stall, ack the cycle after stb): i_cmd_stb at cycle N → stb at N+1 → ack at N+2 → o_rsp_stb at N+3.
  - Set-address/special: o_rsp_stb at N+1.
- Dropped command (i_cmd_stb while busy): no state change, no response.

Optional Feature:
- UART_WB_TIMEOUT_EN defined:
  - A counter runs while in REQ/WAIT.
  - When it reaches TIMEOUT_CYCLES without ack/err: drop cyc/stb, respond with tag 11, payload 32'hFFFF_FFFF, addr unchanged.
  - The counter clears on every acceptance.
- UART_WB_TIMEOUT_EN not defined: no counter; the block waits indefinitely for ack/err.

Decomposition:
- Package uart_bus_pkg:
  - Command code constants CMD_READ/CMD_WRITE/CMD_ADDR/CMD_SPECIAL.
  - Response tags RSP_RDATA/RSP_WACK/RSP_ADDR/RSP_SPECIAL.
  - Payloads ERR_BUS = 32'hFFFF_FFFE and ERR_TIMEOUT = 32'hFFFF_FFFF.
  - State enum typedef.
- One sub-module, uart_wb_watchdog:
  - Inputs: clear, run. Output: expired.
  - Instantiated only under UART_WB_TIMEOUT_EN.

Test Plan:
- Set address then read: cmd {10, 32'h0000_0100} → rsp {10, 32'h100}; cmd {00, x} with slave returning 32'hCAFE_F00D → o_wb_addr = 0x100, we = 0; rsp {00, 32'hCAFE_F00D} at N+3; internal addr becomes 0x101.
- Write with 3 stall cycles: cmd {01, 32'h1234_5678} at addr 0x20 → stb held 4 cycles, o_wb_data = 32'h1234_5678, we = 1; rsp {01, 32'h1234_5678}; next read goes to 0x21.
- Bus error: slave asserts err and ack together → rsp {11, 32'hFFFF_FFFE}; addr not incremented.
- Busy drop: second i_cmd_stb issued 1 cycle after the first read → only one bus cycle and one response; special {11, 32'h8000_0053} afterwards → rsp {11, 32'h0000_0053}.
- Address wrap: set address 2^AW-1, write → next access on o_wb_addr = 0.
- Timeout (macro on, TIMEOUT_CYCLES = 16): slave never acks → cyc drops after 16 cycles, rsp {11, 32'hFFFF_FFFF}; i_rst_n pulsed low mid-WAIT in a separate run → cyc = 0 immediately, no o_rsp_stb.
